// File: rtl/norm_shift_stage_pkg.sv
// norm_shift_stage_pkg
// Shared FPU package for the normalisation stage. It holds the default mantissa,
// exponent and shift-count widths and the FSM state encoding used by
// norm_shift_stage.
// Ports: none (package only).
package norm_shift_stage_pkg;

  localparam int W_DEF  = 55;
  localparam int EW_DEF = 11;
  localparam int SW_DEF = 6;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_COARSE = 2'd1;
  localparam state_t ST_FINE   = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/norm_barrel_shifter.sv
// norm_barrel_shifter
// Two-step left barrel shifter. A load captures the mantissa and the shift
// amount. The first step shifts by 8*amt[SW-1:3] and the second step shifts by
// amt[2:0]. Zeros fill from the LSB. A registered stage select chooses which
// step a given step_i performs.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-low reset
//   load_i  capture mant_i/amt_i and rearm the coarse step
//   step_i  perform the pending (coarse, then fine) shift
//   mant_i  mantissa to load
//   amt_i   total left-shift amount
//   mant_o  current shifter contents
module norm_barrel_shifter
  import norm_shift_stage_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [W-1:0]  mant_i,
  input  logic [SW-1:0] amt_i,
  output logic [W-1:0]  mant_o
);

  logic [W-1:0]  mant_q, mant_d;
  logic [SW-1:0] amt_q, amt_d;
  logic          fine_q, fine_d;

  always_comb begin
    mant_d = mant_q;
    amt_d  = amt_q;
    fine_d = fine_q;
    if (load_i) begin
      mant_d = mant_i;
      amt_d  = amt_i;
      fine_d = 1'b0;
    end else if (step_i) begin
      if (!fine_q) begin
        mant_d = mant_q << {amt_q[SW-1:3], 3'b000};
        fine_d = 1'b1;
      end else begin
        mant_d = mant_q << amt_q[2:0];
        fine_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mant_q <= '0;
      amt_q  <= '0;
      fine_q <= 1'b0;
    end else begin
      mant_q <= mant_d;
      amt_q  <= amt_d;
      fine_q <= fine_d;
    end
  end

  assign mant_o = mant_q;

endmodule

// File: rtl/norm_shift_stage.sv
// norm_shift_stage
// Normalisation stage. It left-shifts an unnormalised mantissa by the
// leading-zero count and clips the count so that the exponent never goes below
// zero. The shift happens over two cycles (coarse, then fine) and the result is
// held until the downstream block acknowledges it.
//
// state  | meaning
// IDLE   | ready for an operand
// COARSE | byte-granular shift in progress
// FINE   | bit-granular shift in progress
// DONE   | result valid, waiting for ack_i
//
// Ports:
//   clk, rst                      clock and synchronous active-low reset
//   load_i / ready_o              operand handshake (accepted in IDLE only)
//   Mantissa_i, Shift_Value_i,    operand: mantissa, leading-zero count and
//   Exp_i                         biased exponent
//   ack_i / valid_o               result handshake
//   Mantissa_o, Exp_o             normalised mantissa and adjusted exponent
//   underflow_o                   the shift was clipped by the exponent
//   zero_o                        the result is zero
module norm_shift_stage
  import norm_shift_stage_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int EW = EW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  output logic          ready_o,
  input  logic [W-1:0]  Mantissa_i,
  input  logic [SW-1:0] Shift_Value_i,
  input  logic [EW-1:0] Exp_i,
  input  logic          ack_i,
  output logic          valid_o,
  output logic [W-1:0]  Mantissa_o,
  output logic [EW-1:0] Exp_o,
  output logic          underflow_o,
  output logic          zero_o
);

  localparam int MW = (EW > SW) ? EW : SW;

  state_t        state_q, state_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          uf_q, uf_d;
  logic          zero_q, zero_d;

  logic          accept;
  logic          clip;
  logic          zero_in;
  logic [SW-1:0] eff;
  logic [SW-1:0] sh_amt;
  logic [W-1:0]  mant_ld;

  assign accept = load_i && (state_q == ST_IDLE);

  // The clipped shift never exceeds Shift_Value_i, so it always fits in SW bits.
  // This keeps the exponent subtraction below free of wrap-around.
  always_comb begin
    clip    = MW'(Shift_Value_i) > MW'(Exp_i);
    zero_in = (Mantissa_i == '0) || (32'(Shift_Value_i) > W - 1);
    eff     = clip ? SW'(Exp_i) : Shift_Value_i;
    sh_amt  = zero_in ? '0 : eff;
    mant_ld = zero_in ? '0 : Mantissa_i;
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    uf_d    = uf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d = ST_COARSE;
          exp_d   = zero_in ? '0 : (Exp_i - EW'(eff));
          uf_d    = clip && !zero_in;
          zero_d  = zero_in;
        end
      end
      ST_COARSE: state_d = ST_FINE;
      ST_FINE:   state_d = ST_DONE;
      ST_DONE:   if (ack_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      uf_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      uf_q    <= uf_d;
      zero_q  <= zero_d;
    end
  end

  norm_barrel_shifter #(
    .W  (W),
    .SW (SW)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .step_i ((state_q == ST_COARSE) || (state_q == ST_FINE)),
    .mant_i (mant_ld),
    .amt_i  (sh_amt),
    .mant_o (Mantissa_o)
  );

  assign ready_o     = (state_q == ST_IDLE);
  assign valid_o     = (state_q == ST_DONE);
  assign Exp_o       = exp_q;
  assign underflow_o = uf_q;
  assign zero_o      = zero_q;

endmodule

// File: doc/norm_shift_stage.md
NORM_SHIFT_STAGE -- requirements
Module: norm_shift_stage

Interface
REQ-001 Parameter W, default 55, mantissa width.
REQ-002 Parameter EW, default 11, exponent width.
REQ-003 Parameter SW, default 6, shift-count width.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 load_i  input  1  upstream operand valid.
REQ-008 ready_o  output  1  block can accept an operand.
REQ-009 Mantissa_i  input  W  unnormalised mantissa.
REQ-010 Shift_Value_i  input  SW  leading-zero count from the priority codec.
REQ-011 Exp_i  input  EW  biased exponent.
REQ-012 ack_i  input  1  downstream has taken the result.
REQ-013 valid_o  output  1  result valid.
REQ-014 Mantissa_o  output  W  normalised mantissa.
REQ-015 Exp_o  output  EW  adjusted exponent.
REQ-016 underflow_o  output  1  requested shift was clipped by the exponent.
REQ-017 zero_o  output  1  result is zero.

Function
REQ-018 The FSM SHALL have the states IDLE, COARSE, FINE and DONE.
REQ-019 ready_o SHALL be 1 only in IDLE.
REQ-020 An operand SHALL be accepted when load_i=1 and ready_o=1, which registers Mantissa_i, Exp_i and the effective shift and moves the FSM to COARSE.
REQ-021 The effective shift SHALL be min(Shift_Value_i, Exp_i).
REQ-022 underflow_o SHALL be set when Shift_Value_i > Exp_i.
REQ-023 COARSE SHALL left-shift the mantissa by 8*eff[5:3] and move to FINE.
REQ-024 FINE SHALL left-shift by eff[2:0], zero-filling from the LSB, and move to DONE.
REQ-025 Latency: an operand accepted at edge N SHALL give valid_o=1 after edge N+2.
REQ-026 In DONE, valid_o=1 and all outputs SHALL stay stable until ack_i=1, after which the next edge moves to IDLE with valid_o=0.
REQ-027 load_i SHALL be ignored in COARSE, FINE and DONE, with no queuing.
REQ-028 Exp_o SHALL equal Exp_i - eff and SHALL never wrap below 0.
REQ-029 If Mantissa_i == 0 or Shift_Value_i > W-1, then zero_o=1, Mantissa_o=0, Exp_o=0 and underflow_o=0.
REQ-030 Shift_Value_i=0 SHALL pass the mantissa and exponent through unchanged, still with the 2-cycle latency.
REQ-031 ack_i while valid_o=0 SHALL have no effect.

Reset
REQ-032 When rst=0 at a clock edge, the FSM SHALL go to IDLE and valid_o, underflow_o, zero_o, Mantissa_o and Exp_o SHALL be 0; ready_o SHALL be 1 after that edge.
REQ-033 Reset in any state, including mid-shift, SHALL discard the in-flight operand without producing a partial result.

Structure
REQ-034 The W, EW and SW defaults and the FSM state encoding SHALL be in the shared FPU package.
REQ-035 The coarse/fine shifter SHALL be one sub-module, norm_barrel_shifter, with a registered stage select; the FSM and exponent logic stay in the top module.

Verification
REQ-036 Mantissa_i=55'h04_0000_0000_0000, Shift=4, Exp=1023 -> Mantissa_o=55'h40_0000_0000_0000, Exp_o=1019, valid_o 2 cycles after accept, flags 0.
REQ-037 Shift=20, Exp=5, Mantissa bit 34 set -> shift clipped to 5, Mantissa_o bit 39 set, Exp_o=0, underflow_o=1.
REQ-038 Mantissa_i=0, Shift=54 -> zero_o=1, Mantissa_o=0, Exp_o=0; Shift=60 with a nonzero mantissa gives the same result.
REQ-039 Hold ack_i=0 for 3 cycles in DONE with load_i=1 -> outputs stable, ready_o=0, no second accept; ack_i=1 -> IDLE next cycle.
REQ-040 Assert rst=0 in FINE -> next cycle IDLE, valid_o=0, all outputs 0, ready_o=1; the next operand is processed correctly.
REQ-041 Shift=0, Exp=0, Mantissa=55'h7F_FFFF_FFFF_FFFF -> passthrough, underflow_o=0, latency 2.
